draw_port_arbiter: RTL and testbench

- Shares the single VGA plot port (x, y, color, plot) among NUM_REQ drawing clients: square drawers, death animation, eraser, score.
- Each client raises req, waits for a one-hot grant, streams pixels, then pulses done to release the port.
- Round-robin fairness, a watchdog that revokes a stuck grant, and one register stage on the pixel path.
- Sits between the drawing units and the VGA adapter.

---
 rtl/draw_pkg.sv | 12 +
 rtl/draw_port_arbiter_if.sv | 24 ++
 rtl/rr_pick.sv | 22 ++
 rtl/draw_port_arbiter.sv | 99 +++++++++
 tb/tb_draw_port_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared widths, arbiter state encodings and defaults for the drawing pipeline
package draw_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
  localparam int TIMEOUT_DEF = 76800;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/draw_port_arbiter_if.sv
// draw_port_arbiter_if: client request/pixel bundle and VGA-side plot port
interface draw_port_arbiter_if import draw_pkg::*; #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     done_in;
  logic [NUM_REQ*X_W-1:0] x_in;
  logic [NUM_REQ*Y_W-1:0] y_in;
  logic [NUM_REQ*C_W-1:0] color_in;
  logic [NUM_REQ-1:0]     plot_in;
  logic [NUM_REQ-1:0]     gnt;
  logic [X_W-1:0]         x_out;
  logic [Y_W-1:0]         y_out;
  logic [C_W-1:0]         color_out;
  logic                   plot_out;
  logic                   busy;
  logic                   timeout_err;
  modport master (
    output req, done_in, x_in, y_in, color_in, plot_in,
    input  gnt, x_out, y_out, color_out, plot_out, busy, timeout_err
  );
  modport slave (
    input  req, done_in, x_in, y_in, color_in, plot_in,
    output gnt, x_out, y_out, color_out, plot_out, busy, timeout_err
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker starting one past the last served client
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);
  logic [NUM_REQ-1:0] rot;
  assign valid_o = |req_i;
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    pick_o = '0;
    rot = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rot = req_i >> ((int'(last_i) + i) % NUM_REQ);
      if (rot[0]) pick_o = NUM_REQ'(1) << ((int'(last_i) + i) % NUM_REQ);
    end
  end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin owner of the single VGA plot port with grant watchdog
module draw_port_arbiter import draw_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 17
) (
  input logic              clk,
  input logic              reset,
  draw_port_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
  logic               pick_v;
  logic [IDX_W-1:0]   last_q, last_d, g;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [C_W-1:0]     c_q, c_d;
  logic               plot_q, plot_d, to_q, to_d;
  logic               ext, to;
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .pick_o (pick),
    .valid_o(pick_v)
  );
  // index of the current grant holder
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt_q[i]) g = IDX_W'(i);
  end
  assign ext = bus.done_in[g] | ~bus.req[g];
  assign to  = (wd_q == CNT_W'(TIMEOUT - 1)) & ~ext;
  // next state, grant, watchdog and pixel path; a watchdog revoke drops its pixel
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wd_d    = wd_q;
    x_d     = '0;
    y_d     = '0;
    c_d     = '0;
    plot_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: if (pick_v) begin
        state_d = ARB_GRANT;
        gnt_d   = pick;
        wd_d    = '0;
      end
      ARB_GRANT: begin
        x_d    = bus.x_in[g*X_W +: X_W];
        y_d    = bus.y_in[g*Y_W +: Y_W];
        c_d    = bus.color_in[g*C_W +: C_W];
        plot_d = bus.plot_in[g] & ~to;
        to_d   = to;
        wd_d   = wd_q + 1'b1;
        if (ext | to) begin
          state_d = ARB_RELEASE;
          gnt_d   = '0;
          last_d  = g;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      to_q    <= to_d;
    end
  end
  assign bus.gnt         = gnt_q;
  assign bus.busy        = |gnt_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.color_out   = c_q;
  assign bus.plot_out    = plot_q;
  assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb_draw_port_arbiter: directed scoreboard bench for the VGA port arbiter
module tb_draw_port_arbiter;
  typedef struct { int cyc; logic [3:0] g; } gev_t;
  typedef struct { int cyc; logic [8:0] x; logic [7:0] y; logic [2:0] c; } pev_t;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_g = '0;
  gev_t gq[$];
  pev_t pq[$];
  int   tq[$];
  gev_t ge;
  pev_t pe;
  int   te;
  draw_port_arbiter_if #(.NUM_REQ(4)) bus ();
  draw_port_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic exp_g(input int dc, input logic [3:0] g);
    gq.push_back('{cyc + dc, g});
  endtask
  task automatic exp_p(input int dc, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    pq.push_back('{cyc + dc, x, y, c});
  endtask
  task automatic set_pix(input int k, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c, input logic p);
    bus.x_in[k*9 +: 9]     = x;
    bus.y_in[k*8 +: 8]     = y;
    bus.color_in[k*3 +: 3] = c;
    bus.plot_in[k]         = p;
  endtask
  task automatic pix(input int k, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    set_pix(k, x, y, c, 1'b1);
    exp_p(1, x, y, c);
    step();
    bus.plot_in[k] = 1'b0;
  endtask
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (!$onehot0(bus.gnt)) begin
      errors++;
      $display("FAIL gnt_onehot: got %b (cyc %0d)", bus.gnt, cyc);
    end
    if (bus.gnt !== prev_g) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected: got %b at cyc %0d, expected no change", bus.gnt, cyc);
      end else begin
        ge = gq.pop_front();
        if (bus.gnt !== ge.g || cyc != ge.cyc) begin
          errors++;
          $display("FAIL gnt: got %b at cyc %0d expected %b at cyc %0d", bus.gnt, cyc, ge.g, ge.cyc);
        end
        checks++;
        if (bus.busy !== (ge.g != 4'b0)) begin
          errors++;
          $display("FAIL busy: got %b expected %b (cyc %0d)", bus.busy, ge.g != 4'b0, cyc);
        end
      end
      prev_g = bus.gnt;
    end
    if (bus.plot_out !== 1'b0) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got plot=%b x=%0d y=%0d c=%0d at cyc %0d", bus.plot_out, bus.x_out, bus.y_out, bus.color_out, cyc);
      end else begin
        pe = pq.pop_front();
        if (bus.x_out !== pe.x || bus.y_out !== pe.y || bus.color_out !== pe.c || cyc != pe.cyc) begin
          errors++;
          $display("FAIL pix: got x=%0d y=%0d c=%0d at cyc %0d expected x=%0d y=%0d c=%0d at cyc %0d",
                   bus.x_out, bus.y_out, bus.color_out, cyc, pe.x, pe.y, pe.c, pe.cyc);
        end
      end
    end
    if (bus.timeout_err !== 1'b0) begin
      checks++;
      if (tq.size() == 0) begin
        errors++;
        $display("FAIL timeout_unexpected: got %b at cyc %0d", bus.timeout_err, cyc);
      end else begin
        te = tq.pop_front();
        if (cyc != te) begin
          errors++;
          $display("FAIL timeout: got pulse at cyc %0d expected cyc %0d", cyc, te);
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.done_in = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.color_in = '0;
    bus.plot_in = '0;
    step(3);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_x", 32'(bus.x_out), 0);
    chk("rst_y", 32'(bus.y_out), 0);
    chk("rst_color", 32'(bus.color_out), 0);
    chk("rst_plot", 32'(bus.plot_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(2);
    // single client: grant after one edge, pixel after one more
    bus.req = 4'b0001;
    exp_g(1, 4'b0001);
    step();
    pix(0, 9'd10, 8'd20, 3'b100);
    bus.done_in[0] = 1'b1;
    bus.req[0] = 1'b0;
    exp_g(1, 4'b0000);
    step();
    bus.done_in[0] = 1'b0;
    step(2);
    // fresh reset so client 0 has priority again; order 0,2,0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    bus.req = 4'b0101;
    exp_g(1, 4'b0001);
    step();
    set_pix(2, 9'd77, 8'd77, 3'd2, 1'b1);
    pix(0, 9'd1, 8'd2, 3'd1);
    bus.done_in[0] = 1'b1;
    exp_g(1, 4'b0000);
    exp_g(3, 4'b0100);
    step();
    bus.done_in[0] = 1'b0;
    step(2);
    pix(2, 9'd100, 8'd200, 3'd7);
    bus.done_in[2] = 1'b1;
    bus.req[2] = 1'b0;
    exp_g(1, 4'b0000);
    exp_g(3, 4'b0001);
    step();
    bus.done_in[2] = 1'b0;
    step(2);
    pix(0, 9'd3, 8'd4, 3'd5);
    bus.done_in[0] = 1'b1;
    bus.req[0] = 1'b0;
    exp_g(1, 4'b0000);
    step();
    bus.done_in[0] = 1'b0;
    step(2);
    // done with a pixel in the same cycle, then client 3 stalls into the watchdog
    bus.req[1] = 1'b1;
    exp_g(1, 4'b0010);
    step();
    set_pix(1, 9'd55, 8'd66, 3'd3, 1'b1);
    bus.done_in[1] = 1'b1;
    bus.req = 4'b1001;
    exp_p(1, 9'd55, 8'd66, 3'd3);
    exp_g(1, 4'b0000);
    exp_g(3, 4'b1000);
    step();
    bus.done_in[1] = 1'b0;
    bus.plot_in[1] = 1'b0;
    set_pix(3, 9'd300, 8'd100, 3'd5, 1'b1);
    for (int j = 0; j < 15; j++) exp_p(3 + j, 9'd300, 8'd100, 3'd5);
    exp_g(18, 4'b0000);
    tq.push_back(cyc + 18);
    exp_g(20, 4'b0001);
    step(18);
    bus.plot_in[3] = 1'b0;
    bus.req[3] = 1'b0;
    step(2);
    pix(0, 9'd9, 8'd8, 3'd6);
    bus.done_in[0] = 1'b1;
    bus.req[0] = 1'b0;
    exp_g(1, 4'b0000);
    step();
    bus.done_in[0] = 1'b0;
    step(2);
    // client 2 drops req without done; client 1 plots while not granted
    bus.req[2] = 1'b1;
    exp_g(1, 4'b0100);
    step();
    set_pix(1, 9'd11, 8'd11, 3'd1, 1'b1);
    pix(2, 9'd12, 8'd13, 3'd2);
    step(2);
    bus.req[2] = 1'b0;
    exp_g(1, 4'b0000);
    step();
    bus.plot_in[1] = 1'b0;
    step(2);
    // reset during an active grant with a pixel in flight
    bus.req[1] = 1'b1;
    exp_g(1, 4'b0010);
    step();
    set_pix(1, 9'd40, 8'd41, 3'd6, 1'b1);
    exp_p(1, 9'd40, 8'd41, 3'd6);
    step();
    reset = 1'b1;
    bus.req[1] = 1'b0;
    exp_g(1, 4'b0000);
    step();
    reset = 1'b0;
    bus.plot_in[1] = 1'b0;
    chk("midrst_plot", 32'(bus.plot_out), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_x", 32'(bus.x_out), 0);
    step();
    // last must be back at 3: req 1100 picks client 2, a stale last=2 would pick 3
    bus.req = 4'b1100;
    exp_g(1, 4'b0100);
    step();
    bus.done_in[2] = 1'b1;
    bus.req = 4'b0000;
    exp_g(1, 4'b0000);
    step();
    bus.done_in[2] = 1'b0;
    step(5);
    chk("left_gnt", 32'(gq.size()), 0);
    chk("left_pix", 32'(pq.size()), 0);
    chk("left_timeout", 32'(tq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
